// File: rtl/icache_dataram_arb.sv
// Instruction-cache data RAM arbiter.
// Three requesters share one single-port data RAM: refill writes, demand (hit)
// reads and prefetch reads. At most one of them is granted each cycle. A read
// grant produces a response one cycle later, carrying the RAM read data and the
// ID and prefetch flag captured at grant time.
module icache_dataram_arb #(
    parameter int INDEX_WIDTH = 9,
    parameter int DATA_WIDTH  = 256,
    parameter int TXNID_WIDTH = 5,
    parameter int STARVE_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    // Refill write port
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic                   wr_way,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [DATA_WIDTH-1:0]  wr_data,

    // Demand read port
    input  logic                   rd_vld,
    output logic                   rd_rdy,
    input  logic                   rd_way,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    input  logic [TXNID_WIDTH-1:0] rd_txnid,

    // Prefetch read port
    input  logic                   pf_vld,
    output logic                   pf_rdy,
    input  logic                   pf_way,
    input  logic [INDEX_WIDTH-1:0] pf_index,
    input  logic [TXNID_WIDTH-1:0] pf_txnid,

    // Data RAM port
    output logic                   ram_en,
    output logic                   ram_we,
    output logic                   ram_way,
    output logic [INDEX_WIDTH-1:0] ram_index,
    output logic [DATA_WIDTH-1:0]  ram_wdata,
    input  logic [DATA_WIDTH-1:0]  ram_rdata,

    // Read response (no backpressure)
    output logic                   rsp_vld,
    output logic                   rsp_pf,
    output logic [TXNID_WIDTH-1:0] rsp_txnid,
    output logic [DATA_WIDTH-1:0]  rsp_data
);

    localparam int                   CNT_WIDTH = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STARVE_MAX);

    // Which requester owns the RAM this cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD,
        GNT_PF
    } gnt_e;

    gnt_e                   gnt;
    logic                   starve_force;
    logic [CNT_WIDTH-1:0]   starve_cnt;
    logic [CNT_WIDTH-1:0]   starve_cnt_nxt;

    // Response pipeline: one stage, aligned with the RAM read latency.
    logic                   rsp_vld_q;
    logic                   rsp_pf_q;
    logic [TXNID_WIDTH-1:0] rsp_txnid_q;

    // Grant selection: refill > demand > prefetch, except that a demand read
    // which has lost STARVE_MAX times in a row jumps ahead of the refill.
    // NOTE: every signal written in an always_comb gets a default on entry so
    // that no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt          = GNT_NONE;
        starve_force = rd_vld && (starve_cnt == CNT_MAX);
        if (rst) begin
            gnt = GNT_NONE;
        end else if (starve_force) begin
            gnt = GNT_RD;
        end else if (wr_vld) begin
            gnt = GNT_WR;
        end else if (rd_vld) begin
            gnt = GNT_RD;
        end else if (pf_vld) begin
            gnt = GNT_PF;
        end
    end

    assign wr_rdy = (gnt == GNT_WR);
    assign rd_rdy = (gnt == GNT_RD);
    assign pf_rdy = (gnt == GNT_PF);

    // RAM request mux: address from the winning requester; write data is only
    // meaningful on a refill so it is taken from the refill port unconditionally.
    always_comb begin
        ram_en    = (gnt != GNT_NONE);
        ram_we    = (gnt == GNT_WR);
        ram_way   = wr_way;
        ram_index = wr_index;
        ram_wdata = wr_data;
        case (gnt)
            GNT_RD: begin
                ram_way   = rd_way;
                ram_index = rd_index;
            end
            GNT_PF: begin
                ram_way   = pf_way;
                ram_index = pf_index;
            end
            default: begin
            end
        endcase
    end

    // Starvation counter next state: counts consecutive demand-read losses,
    // saturating at STARVE_MAX; any demand grant or idle demand port clears it.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (!rd_vld || rd_rdy) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt_nxt = starve_cnt + 1'b1;
        end
    end

    // Starvation counter register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the simulator runs the blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Capture the ID and origin of each read grant for the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q   <= 1'b0;
            rsp_pf_q    <= 1'b0;
            rsp_txnid_q <= '0;
        end else begin
            rsp_vld_q   <= rd_rdy || pf_rdy;
            rsp_pf_q    <= pf_rdy;
            rsp_txnid_q <= pf_rdy ? pf_txnid : rd_txnid;
        end
    end

    // Response outputs. Reset masks them in the same cycle, so a read granted
    // just before reset rises never surfaces a response.
    assign rsp_vld   = rsp_vld_q && !rst;
    assign rsp_pf    = rsp_pf_q && !rst;
    assign rsp_txnid = rst ? '0 : rsp_txnid_q;
    assign rsp_data  = ram_rdata;

endmodule

// File: tb/tb_icache_dataram_arb.sv
// Self-checking bench for icache_dataram_arb: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model
// (priority rules, a loss counter, a shadow copy of the RAM contents and the
// response expected one cycle after each read grant).
module tb_icache_dataram_arb;

    localparam int IW = 9;
    localparam int DW = 256;
    localparam int TW = 5;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_vld, wr_rdy, wr_way;
    logic [IW-1:0] wr_index;
    logic [DW-1:0] wr_data;
    logic          rd_vld, rd_rdy, rd_way;
    logic [IW-1:0] rd_index;
    logic [TW-1:0] rd_txnid;
    logic          pf_vld, pf_rdy, pf_way;
    logic [IW-1:0] pf_index;
    logic [TW-1:0] pf_txnid;
    logic          ram_en, ram_we, ram_way;
    logic [IW-1:0] ram_index;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          rsp_vld, rsp_pf;
    logic [TW-1:0] rsp_txnid;
    logic [DW-1:0] rsp_data;

    always #5 clk = ~clk;

    icache_dataram_arb #(
        .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .TXNID_WIDTH(TW), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_way(wr_way), .wr_index(wr_index), .wr_data(wr_data),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_way(rd_way), .rd_index(rd_index), .rd_txnid(rd_txnid),
        .pf_vld(pf_vld), .pf_rdy(pf_rdy), .pf_way(pf_way), .pf_index(pf_index), .pf_txnid(pf_txnid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_way(ram_way), .ram_index(ram_index),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rsp_vld(rsp_vld), .rsp_pf(rsp_pf), .rsp_txnid(rsp_txnid), .rsp_data(rsp_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            m_cnt;        // consecutive demand losses
    bit            pend_vld;     // a read was granted last cycle
    bit            pend_pf;
    logic [TW-1:0] pend_txnid;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] shadow  [int]; // expected RAM contents
    logic [DW-1:0] env_ram [int]; // RAM behind the DUT

    function automatic int key(input logic w, input logic [IW-1:0] i);
        return int'({w, i});
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input int k);
        return shadow.exists(k) ? shadow[k] : '0;
    endfunction

    function automatic logic [DW-1:0] env_rd(input int k);
        return env_ram.exists(k) ? env_ram[k] : '0;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge against the model,
    // then advance the model and the RAM at the rising edge.
    task automatic cycle();
        int            g;        // 0 none, 1 wr, 2 rd, 3 pf
        bit            exp_rsp;
        bit            e_en, e_we;
        int            e_key;
        logic [DW-1:0] e_wd, e_rd;
        @(negedge clk);
        if (rst)                       g = 0;
        else if (rd_vld && m_cnt == SM) g = 2;
        else if (wr_vld)               g = 1;
        else if (rd_vld)               g = 2;
        else if (pf_vld)               g = 3;
        else                           g = 0;

        chk("wr_rdy", DW'(wr_rdy), DW'(g == 1));
        chk("rd_rdy", DW'(rd_rdy), DW'(g == 2));
        chk("pf_rdy", DW'(pf_rdy), DW'(g == 3));
        chk("ram_en", DW'(ram_en), DW'(g != 0));
        chk("ram_we", DW'(ram_we), DW'(g == 1));
        if (g == 1) begin
            chk("ram_addr_wr", DW'({ram_way, ram_index}), DW'({wr_way, wr_index}));
            chk("ram_wdata", ram_wdata, wr_data);
        end else if (g == 2) begin
            chk("ram_addr_rd", DW'({ram_way, ram_index}), DW'({rd_way, rd_index}));
        end else if (g == 3) begin
            chk("ram_addr_pf", DW'({ram_way, ram_index}), DW'({pf_way, pf_index}));
        end

        exp_rsp = pend_vld && !rst;
        chk("rsp_vld", DW'(rsp_vld), DW'(exp_rsp));
        if (exp_rsp) begin
            chk("rsp_pf", DW'(rsp_pf), DW'(pend_pf));
            chk("rsp_txnid", DW'(rsp_txnid), DW'(pend_txnid));
            chk("rsp_data", rsp_data, pend_data);
        end
        if (rst) begin
            chk("rsp_pf_rst", DW'(rsp_pf), '0);
            chk("rsp_txnid_rst", DW'(rsp_txnid), '0);
        end
        chk("starve_cnt", DW'(dut.starve_cnt), DW'(m_cnt));

        e_en  = ram_en;
        e_we  = ram_we;
        e_key = key(ram_way, ram_index);
        e_wd  = ram_wdata;

        @(posedge clk);
        pend_vld   = (g == 2) || (g == 3);
        pend_pf    = (g == 3);
        pend_txnid = (g == 3) ? pf_txnid : rd_txnid;
        if (g == 2) pend_data = shadow_rd(key(rd_way, rd_index));
        if (g == 3) pend_data = shadow_rd(key(pf_way, pf_index));
        if (g == 1) shadow[key(wr_way, wr_index)] = wr_data;
        if (rst || !rd_vld || g == 2) m_cnt = 0;
        else if (m_cnt < SM)          m_cnt++;

        e_rd = rnd_data();
        if (e_en && e_we)  env_ram[e_key] = e_wd;
        else if (e_en)     e_rd = env_rd(e_key);
        #1;
        ram_rdata = e_rd;
    endtask

    task automatic clear_vld();
        wr_vld = 1'b0;
        rd_vld = 1'b0;
        pf_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_vld();
        wr_way = 1'b0; wr_index = '0; wr_data = '0;
        rd_way = 1'b0; rd_index = '0; rd_txnid = '0;
        pf_way = 1'b0; pf_index = '0; pf_txnid = '0;
        ram_rdata = '0;
        m_cnt = 0;
        pend_vld = 1'b0; pend_pf = 1'b0; pend_txnid = '0; pend_data = '0;

        // Reset with requests pending: everything held low.
        cycle();
        wr_vld = 1'b1; rd_vld = 1'b1; pf_vld = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        clear_vld();

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) cycle();

        // Priority: all three valid, each dropped once served.
        wr_vld = 1'b1; wr_way = 1'b0; wr_index = 9'd3; wr_data = rnd_data();
        rd_vld = 1'b1; rd_way = 1'b0; rd_index = 9'd3; rd_txnid = 5'd3;
        pf_vld = 1'b1; pf_way = 1'b1; pf_index = 9'd4; pf_txnid = 5'd17;
        cycle();
        wr_vld = 1'b0;
        cycle();
        rd_vld = 1'b0;
        cycle();
        pf_vld = 1'b0;
        cycle();
        cycle();

        // Starvation: write and demand read held together.
        wr_vld = 1'b1;
        rd_vld = 1'b1; rd_txnid = 5'd11;
        for (int i = 0; i < 12; i++) begin
            wr_way = 1'($urandom); wr_index = IW'($urandom_range(0, 3)); wr_data = rnd_data();
            rd_way = 1'($urandom); rd_index = IW'($urandom_range(0, 3));
            cycle();
        end
        clear_vld();
        cycle();

        // Coherence: write then read of the same line in the next cycle.
        wr_vld = 1'b1; wr_way = 1'b1; wr_index = 9'd7; wr_data = {32{8'hA5}};
        cycle();
        wr_vld = 1'b0;
        rd_vld = 1'b1; rd_way = 1'b1; rd_index = 9'd7; rd_txnid = 5'd9;
        cycle();
        rd_vld = 1'b0;
        cycle();
        cycle();

        // Streaming: 8 back-to-back prefetches.
        for (int i = 0; i < 8; i++) begin
            pf_vld = 1'b1; pf_way = 1'(i); pf_index = IW'(i); pf_txnid = TW'(i);
            cycle();
        end
        pf_vld = 1'b0;
        cycle();
        cycle();

        // Reset right after a read grant, with starvation built up beforehand.
        wr_vld = 1'b1; rd_vld = 1'b1; rd_txnid = 5'd21;
        cycle();
        cycle();
        wr_vld = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; rd_vld = 1'b0;
        cycle();
        cycle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            wr_vld   = 1'($urandom);
            rd_vld   = 1'($urandom);
            pf_vld   = 1'($urandom);
            wr_way   = 1'($urandom); wr_index = IW'($urandom_range(0, 3)); wr_data = rnd_data();
            rd_way   = 1'($urandom); rd_index = IW'($urandom_range(0, 3)); rd_txnid = TW'($urandom);
            pf_way   = 1'($urandom); pf_index = IW'($urandom_range(0, 3)); pf_txnid = TW'($urandom);
            cycle();
        end
        rst = 1'b0;
        clear_vld();
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_dataram_arb.md
ICACHE_DATARAM_ARB -- requirements
Module: icache_dataram_arb

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 9, meaning data RAM set index width (512 sets).
REQ-002 SHALL have parameter DATA_WIDTH, default 256, meaning cache line width in bits.
REQ-003 SHALL have parameter TXNID_WIDTH, default 5, meaning read transaction ID width.
REQ-004 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive demand-read losses that forces a read grant.
REQ-005 SHALL have ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_vld  in  1  refill write request.
- wr_rdy  out  1  refill write granted this cycle.
- wr_way  in  1  refill way.
- wr_index  in  INDEX_WIDTH  refill set.
- wr_data  in  DATA_WIDTH  refill line.
- rd_vld  in  1  demand (hit) read request.
- rd_rdy  out  1  demand read granted.
- rd_way  in  1  demand read way.
- rd_index  in  INDEX_WIDTH  demand read set.
- rd_txnid  in  TXNID_WIDTH  demand read ID.
- pf_vld  in  1  prefetch read request.
- pf_rdy  out  1  prefetch read granted.
- pf_way  in  1  prefetch read way.
- pf_index  in  INDEX_WIDTH  prefetch read set.
- pf_txnid  in  TXNID_WIDTH  prefetch read ID.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_way  out  1  accessed way.
- ram_index  out  INDEX_WIDTH  accessed set.
- ram_wdata  out  DATA_WIDTH  write data.
- ram_rdata  in  DATA_WIDTH  read data; valid exactly 1 cycle after a read access.
- rsp_vld  out  1  read response valid.
- rsp_pf  out  1  response belongs to a prefetch.
- rsp_txnid  out  TXNID_WIDTH  response ID.
- rsp_data  out  DATA_WIDTH  response line.

Function
REQ-006 SHALL grant at most one requester per cycle; a handshake completes when vld and rdy are both high in the same cycle; rdy SHALL be combinational from the current vld inputs and the starvation state.
REQ-007 SHALL use default priority wr > rd > pf.
REQ-008 SHALL keep a starvation counter starve_cnt (0..STARVE_MAX):
- incremented when rd_vld=1 and rd_rdy=0;
- cleared when a demand read is granted or when rd_vld=0.
REQ-009 When starve_cnt==STARVE_MAX and rd_vld=1, SHALL grant rd over wr for that cycle.
REQ-010 SHALL grant pf only when wr_vld=0 and rd_vld=0.
REQ-011 SHALL drive the RAM signals combinationally from the granted request:
- ram_en=1 on any grant; ram_we=1 only on a wr grant;
- ram_way, ram_index and ram_wdata taken from the granted source;
- with no grant, ram_en=0, ram_we=0 and the remaining RAM outputs are don't-care.
REQ-012 SHALL register the txnid and pf flag of each read grant for one cycle.
REQ-013 In the cycle after a read grant, SHALL assert rsp_vld=1 with rsp_data=ram_rdata, plus the registered rsp_txnid and rsp_pf; rsp_vld=0 in all other cycles.
REQ-014 rsp has no backpressure; the consumer SHALL accept every response, and back-to-back reads SHALL produce back-to-back responses at a throughput of 1 per cycle.
REQ-015 A write followed by a read to the same way/index in the next cycle SHALL return the newly written data (RAM ordering; no bypass required).
REQ-016 A write and a read to the same way/index that are valid in the same cycle SHALL be serialized by priority; a read granted later SHALL observe the write.
REQ-017 starve_cnt SHALL saturate at STARVE_MAX and never wrap.

Reset
REQ-018 While rst=1, all of the following SHALL be 0, overriding any other activity: starve_cnt, the registered response state, rsp_vld, rsp_pf, rsp_txnid, wr_rdy, rd_rdy, pf_rdy, ram_en and ram_we.
REQ-019 A read granted in the cycle before rst rises SHALL produce no response.

Verification
REQ-020 Idle check: all vld=0 for 10 cycles -> ram_en=0 and rsp_vld=0 throughout.
REQ-021 Priority check: wr, rd and pf all valid for one cycle (rd_txnid=3) ->
- cycle 0: wr_rdy=1, ram_we=1;
- cycle 1 (pf still valid): rd granted;
- cycle 2: rsp_vld=1, rsp_txnid=3, rsp_pf=0;
- pf granted in cycle 2.
REQ-022 Starvation check: wr_vld=1 and rd_vld=1 held continuously, STARVE_MAX=4 ->
- wr granted in cycles 0-3, rd granted in cycle 4;
- starve_cnt returns to 0 and the pattern repeats.
REQ-023 Coherence check: write 0xA5.. to way1/index 7, then a demand read of way1/index 7 in the next cycle -> rsp_data=0xA5.. two cycles after the write.
REQ-024 Streaming check: 8 back-to-back pf reads with txnids 0-7 -> 8 consecutive rsp_vld cycles with rsp_pf=1 and txnids in order.
REQ-025 Reset check: rst asserted in the cycle after a read grant -> rsp_vld=0 and starve_cnt=0 in the following cycle.
